weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader_pkg.sv | 15 +
 rtl/wl_checksum.sv | 28 ++
 rtl/weight_loader.sv | 132 +++++++++++++
 tb/tb_weight_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_loader_pkg.sv
// Shared types and constants for the weight loader: frame geometry and FSM states.
package weight_loader_pkg;

   localparam int NUM_WEIGHTS = 4;
   localparam int W_WIDTH     = 8;
   localparam int CSUM_WIDTH  = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_CHECK  = 2'd2,
      ST_COMMIT = 2'd3
   } state_e;

endpackage

// File: rtl/wl_checksum.sv
// Running modulo-256 sum of the weight bytes of the frame being received.
module wl_checksum
   import weight_loader_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  acc_i,
   input  logic [CSUM_WIDTH-1:0] byte_i,
   output logic [CSUM_WIDTH-1:0] sum_o
);

   logic [CSUM_WIDTH-1:0] sum_q;

   // The first weight byte arrives while idle, so clear and accumulate can coincide.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sum_q <= '0;
      end else if (clear_i) begin
         sum_q <= acc_i ? byte_i : '0;
      end else if (acc_i) begin
         sum_q <= sum_q + byte_i;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/weight_loader.sv
// Receives framed weight bytes, verifies the checksum and commits them atomically
// to the active weight registers that feed the hidden neuron.
module weight_loader #(
   parameter int NUM_WEIGHTS = weight_loader_pkg::NUM_WEIGHTS,
   parameter int W_WIDTH     = weight_loader_pkg::W_WIDTH
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [7:0]         byte_i,
   input  logic               byte_valid_i,
   output logic               byte_ready_o,
   input  logic               abort_i,
   output logic [W_WIDTH-1:0] w0_o,
   output logic [W_WIDTH-1:0] w1_o,
   output logic [W_WIDTH-1:0] w2_o,
   output logic [W_WIDTH-1:0] w3_o,
   output logic               weights_valid_o,
   output logic               err_o,
   output logic [7:0]         commit_count_o
);

   import weight_loader_pkg::state_e;
   import weight_loader_pkg::ST_IDLE;
   import weight_loader_pkg::ST_LOAD;
   import weight_loader_pkg::ST_CHECK;
   import weight_loader_pkg::ST_COMMIT;
   import weight_loader_pkg::CSUM_WIDTH;

   localparam int                IDX_W    = $clog2(NUM_WEIGHTS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WEIGHTS - 1);

   state_e                state_q;
   logic [IDX_W-1:0]      idx_q;
   logic [W_WIDTH-1:0]    shadow_q [NUM_WEIGHTS];
   logic [W_WIDTH-1:0]    active_q [NUM_WEIGHTS];
   logic                  ready_q;
   logic                  valid_q;
   logic                  err_q;
   logic [7:0]            count_q;
   logic                  accept;
   logic                  acc_weight;
   logic [CSUM_WIDTH-1:0] sum;

   // A byte offered alongside abort is refused even though ready may read high.
   assign accept     = byte_valid_i && ready_q && !abort_i;
   assign acc_weight = accept && (state_q == ST_IDLE || state_q == ST_LOAD);

   wl_checksum u_checksum (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (state_q == ST_IDLE),
      .acc_i   (acc_weight),
      .byte_i  (byte_i),
      .sum_o   (sum)
   );

   // NOTE: every register here uses <= so all of them see pre-edge values of each other.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         count_q <= '0;
         // NOTE: the small shadow array is reset too, so no stale weights survive a reset.
         for (int i = 0; i < NUM_WEIGHTS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         if (abort_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (accept) begin
                     shadow_q[0] <= W_WIDTH'(byte_i);
                     idx_q       <= IDX_W'(1);
                     state_q     <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  if (accept) begin
                     shadow_q[idx_q] <= W_WIDTH'(byte_i);
                     if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        state_q <= ST_CHECK;
                     end else begin
                        idx_q <= idx_q + IDX_W'(1);
                     end
                  end
               end
               ST_CHECK: begin
                  if (accept) begin
                     if (byte_i == sum) begin
                        state_q <= ST_COMMIT;
                        ready_q <= 1'b0;
                     end else begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                     end
                  end
               end
               ST_COMMIT: begin
                  for (int i = 0; i < NUM_WEIGHTS; i++) begin
                     active_q[i] <= shadow_q[i];
                  end
                  count_q <= count_q + 8'd1;
                  err_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign byte_ready_o    = ready_q;
   assign weights_valid_o = valid_q;
   assign err_o           = err_q;
   assign commit_count_o  = count_q;
   assign w0_o            = active_q[0];
   assign w1_o            = active_q[1];
   assign w2_o            = active_q[2];
   assign w3_o            = active_q[3];

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: frame commit timing, checksum errors, abort, reset and wrap.
module tb_weight_loader;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [7:0] byte_i;
   logic       byte_valid_i;
   logic       byte_ready_o;
   logic       abort_i;
   logic [7:0] w0_o, w1_o, w2_o, w3_o;
   logic       weights_valid_o;
   logic       err_o;
   logic [7:0] commit_count_o;
   logic [31:0] w_all;

   int tests_run    = 0;
   int tests_failed = 0;

   weight_loader dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .byte_i          (byte_i),
      .byte_valid_i    (byte_valid_i),
      .byte_ready_o    (byte_ready_o),
      .abort_i         (abort_i),
      .w0_o            (w0_o),
      .w1_o            (w1_o),
      .w2_o            (w2_o),
      .w3_o            (w3_o),
      .weights_valid_o (weights_valid_o),
      .err_o           (err_o),
      .commit_count_o  (commit_count_o)
   );

   assign w_all = {w0_o, w1_o, w2_o, w3_o};

   always #5 clk_i = ~clk_i;

   // Called just after a falling edge; returns just after the falling edge that follows acceptance.
   task automatic send_byte(input logic [7:0] b, output int stalls);
      stalls       = 0;
      byte_i       = b;
      byte_valid_i = 1'b1;
      while (byte_ready_o !== 1'b1 && stalls < 8) begin
         @(negedge clk_i);
         stalls++;
      end
      if (stalls >= 8) begin
         tests_run++;
         tests_failed++;
         $display("FAIL ready_timeout: byte_ready_o=%b after %0d cycles, required 1", byte_ready_o, stalls);
      end else begin
         @(posedge clk_i);
         @(negedge clk_i);
      end
   endtask

   task automatic send_frame(input logic [39:0] frame);
      int st;
      for (int i = 0; i < 5; i++) send_byte(frame[39-8*i -: 8], st);
      byte_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk_i);
      @(negedge clk_i);
      tests_run++;
      if ({w_all, weights_valid_o, err_o, commit_count_o} !== 42'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: w=%h valid=%b err=%b count=%h, required all 0", w_all, weights_valid_o, err_o, commit_count_o);
      end
      rst_i = 1'b0;
      tests_run++;
      if (byte_ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready: got %b, required 1", byte_ready_o);
      end
   endtask

   task automatic test_good_frame();
      send_frame({8'h10, 8'h20, 8'h30, 8'h40, 8'hA0});
      tests_run++;
      if ({byte_ready_o, weights_valid_o, w_all} !== {1'b0, 1'b0, 32'h0}) begin
         tests_failed++;
         $display("FAIL good_in_commit: ready=%b valid=%b w=%h, required 0 0 00000000", byte_ready_o, weights_valid_o, w_all);
      end
      @(negedge clk_i);
      tests_run++;
      if ({weights_valid_o, w_all, commit_count_o, err_o} !== {1'b1, 32'h10203040, 8'd1, 1'b0}) begin
         tests_failed++;
         $display("FAIL good_commit: valid=%b w=%h count=%0d err=%b, required 1 10203040 1 0", weights_valid_o, w_all, commit_count_o, err_o);
      end
      @(negedge clk_i);
      tests_run++;
      if ({weights_valid_o, byte_ready_o} !== 2'b01) begin
         tests_failed++;
         $display("FAIL good_pulse_end: valid=%b ready=%b, required 0 1", weights_valid_o, byte_ready_o);
      end
   endtask

   task automatic test_bad_checksum();
      int pulses;
      send_frame({8'h01, 8'h02, 8'h03, 8'h04, 8'hFF});
      tests_run++;
      if ({err_o, byte_ready_o} !== 2'b11) begin
         tests_failed++;
         $display("FAIL bad_err: err=%b ready=%b, required 1 1", err_o, byte_ready_o);
      end
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         if (weights_valid_o === 1'b1) pulses++;
      end
      tests_run++;
      if ({pulses[3:0], w_all, commit_count_o, err_o} !== {4'd0, 32'h10203040, 8'd1, 1'b1}) begin
         tests_failed++;
         $display("FAIL bad_hold: pulses=%0d w=%h count=%0d err=%b, required 0 10203040 1 1", pulses, w_all, commit_count_o, err_o);
      end
   endtask

   task automatic test_carry_and_clear();
      send_frame({8'h80, 8'h80, 8'h80, 8'h81, 8'h01});
      @(negedge clk_i);
      tests_run++;
      if ({weights_valid_o, w_all, w3_o, commit_count_o, err_o} !== {1'b1, 32'h80808081, 8'h81, 8'd2, 1'b0}) begin
         tests_failed++;
         $display("FAIL carry_commit: valid=%b w=%h w3=%h count=%0d err=%b, required 1 80808081 81 2 0", weights_valid_o, w_all, w3_o, commit_count_o, err_o);
      end
      @(negedge clk_i);
   endtask

   task automatic test_abort();
      int st;
      send_byte(8'h11, st);
      send_byte(8'h22, st);
      byte_i  = 8'h33;
      abort_i = 1'b1;
      tests_run++;
      if (byte_ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_ready: got %b, required 1", byte_ready_o);
      end
      @(negedge clk_i);
      abort_i      = 1'b0;
      byte_valid_i = 1'b0;
      tests_run++;
      if ({w_all, commit_count_o, err_o} !== {32'h80808081, 8'd2, 1'b0}) begin
         tests_failed++;
         $display("FAIL abort_hold: w=%h count=%0d err=%b, required 80808081 2 0", w_all, commit_count_o, err_o);
      end
      send_frame({8'h05, 8'h06, 8'h07, 8'h08, 8'h1A});
      @(negedge clk_i);
      tests_run++;
      if ({weights_valid_o, w_all, commit_count_o, err_o} !== {1'b1, 32'h05060708, 8'd3, 1'b0}) begin
         tests_failed++;
         $display("FAIL abort_next_frame: valid=%b w=%h count=%0d err=%b, required 1 05060708 3 0", weights_valid_o, w_all, commit_count_o, err_o);
      end
      // Abort raised while in COMMIT must cancel the commit.
      send_frame({8'h01, 8'h01, 8'h01, 8'h01, 8'h04});
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      tests_run++;
      if ({weights_valid_o, w_all, commit_count_o, byte_ready_o} !== {1'b0, 32'h05060708, 8'd3, 1'b1}) begin
         tests_failed++;
         $display("FAIL abort_commit: valid=%b w=%h count=%0d ready=%b, required 0 05060708 3 1", weights_valid_o, w_all, commit_count_o, byte_ready_o);
      end
   endtask

   task automatic test_reset_mid_frame();
      int st;
      send_frame({8'h01, 8'h02, 8'h03, 8'h04, 8'hFF});
      send_byte(8'h11, st);
      send_byte(8'h22, st);
      byte_valid_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      tests_run++;
      if ({w_all, weights_valid_o, err_o, commit_count_o, byte_ready_o} !== {32'h0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
         tests_failed++;
         $display("FAIL reset_mid: w=%h valid=%b err=%b count=%0d ready=%b, required 00000000 0 0 0 1", w_all, weights_valid_o, err_o, commit_count_o, byte_ready_o);
      end
      send_frame({8'h05, 8'h06, 8'h07, 8'h08, 8'h1A});
      @(negedge clk_i);
      tests_run++;
      if ({w_all, commit_count_o} !== {32'h05060708, 8'd1}) begin
         tests_failed++;
         $display("FAIL reset_next_frame: w=%h count=%0d, required 05060708 1", w_all, commit_count_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [79:0] frames;
      int          st;
      int          exp_st;
      frames = {8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h2E};
      for (int i = 0; i < 10; i++) begin
         send_byte(frames[79-8*i -: 8], st);
         exp_st = (i == 5) ? 1 : 0;
         tests_run++;
         if (st !== exp_st) begin
            tests_failed++;
            $display("FAIL b2b_stall[%0d]: stalled %0d cycles, required %0d", i, st, exp_st);
         end
      end
      byte_valid_i = 1'b0;
      @(negedge clk_i);
      tests_run++;
      if ({weights_valid_o, w_all, commit_count_o} !== {1'b1, 32'h0A0B0C0D, 8'd3}) begin
         tests_failed++;
         $display("FAIL b2b_commit: valid=%b w=%h count=%0d, required 1 0A0B0C0D 3", weights_valid_o, w_all, commit_count_o);
      end
   endtask

   task automatic test_wrap();
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < 255; i++) send_frame({8'h10, 8'h20, 8'h30, 8'h40, 8'hA0});
      @(negedge clk_i);
      tests_run++;
      if (commit_count_o !== 8'd255) begin
         tests_failed++;
         $display("FAIL wrap_255: count=%0d, required 255", commit_count_o);
      end
      send_frame({8'h10, 8'h20, 8'h30, 8'h40, 8'hA0});
      @(negedge clk_i);
      tests_run++;
      if ({commit_count_o, err_o, weights_valid_o} !== {8'd0, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL wrap_0: count=%0d err=%b valid=%b, required 0 0 1", commit_count_o, err_o, weights_valid_o);
      end
   endtask

   initial begin
      rst_i        = 1'b1;
      byte_i       = 8'h00;
      byte_valid_i = 1'b0;
      abort_i      = 1'b0;
      @(negedge clk_i);
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_carry_and_clear();
      test_abort();
      test_reset_mid_frame();
      test_back_to_back();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
